timer_counter: RTL and testbench

Programmable down-counting timer, device 1 on the system bridge, decoded at 0x0000_7f00–0x0000_7f0b. Consumes the bridge's shared address, shared write data and DEV1 write enable, and returns read data on DEV1_RD. Raises an interrupt request toward the CP0 interrupt lines when the count expires. Supports one-shot and auto-reload modes.

---
 rtl/timer_pkg.sv | 26 ++
 rtl/timer_counter.sv | 138 +++++++++++++
 tb/tb_timer_counter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the programmable down-counting timer.
//   - FSM state encoding
//   - register offsets (Addr[3:2])
//   - CTRL bit positions and mode encodings
package timer_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StCnt  = 2'd2,
        StInt  = 2'd3
    } state_e;

    localparam logic [1:0] OffCtrl   = 2'b00;
    localparam logic [1:0] OffPreset = 2'b01;
    localparam logic [1:0] OffCount  = 2'b10;

    localparam int unsigned CtrlEnBit   = 0;
    localparam int unsigned CtrlModeLsb = 1;
    localparam int unsigned CtrlModeMsb = 2;
    localparam int unsigned CtrlImBit   = 3;

    localparam logic [1:0] ModeOneShot    = 2'b00;
    localparam logic [1:0] ModeAutoReload = 2'b01;

endpackage

// File: rtl/timer_counter.sv
// Programmable down-counting timer on the system bridge (device 1).
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-high reset, clears all state
//   Addr   - bridge address, only Addr[3:2] decoded
//   WE     - range-qualified write strobe
//   WD     - write data
//   RD     - combinational read data
//   IRQ    - interrupt request (irq_pend masked by CTRL.IM)
module timer_counter
    import timer_pkg::*;
#(
    parameter int unsigned       WIDTH       = 32,
    parameter logic [WIDTH-1:0]  INIT_PRESET = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Addr,
    input  logic             WE,
    input  logic [WIDTH-1:0] WD,
    output logic [WIDTH-1:0] RD,
    output logic             IRQ
);

    logic             en_q, en_d;
    logic [1:0]       mode_q, mode_d;
    logic             im_q, im_d;
    logic [WIDTH-1:0] preset_q, preset_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             irq_pend_q, irq_pend_d;
    state_e           state_q, state_d;

    logic ctrl_we, preset_we, auto_reload, ctrl_ack;

    logic unused_addr;
    assign unused_addr = ^{Addr[31:4], Addr[1:0]};

    assign ctrl_we     = WE && (Addr[3:2] == OffCtrl);
    assign preset_we   = WE && (Addr[3:2] == OffPreset);
    // MODE 1x behaves as one-shot.
    assign auto_reload = (mode_q == ModeAutoReload);

    // A CTRL write acknowledges a pending interrupt, unless it leaves EN and MODE
    // untouched: such a write is a pure mask update and keeps the pending state.
    assign ctrl_ack = ctrl_we &&
                      ({WD[CtrlModeMsb:CtrlModeLsb], WD[CtrlEnBit]} != {mode_q, en_q});

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        irq_pend_d = irq_pend_q;
        en_d       = en_q;
        mode_d     = mode_q;
        im_d       = im_q;
        preset_d   = preset_q;

        if (ctrl_ack) begin
            irq_pend_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (en_q) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                count_d = preset_q;
                state_d = StCnt;
            end
            StCnt: begin
                if (!en_q) begin
                    state_d = StIdle;
                end else if (count_q > WIDTH'(1)) begin
                    count_d = count_q - WIDTH'(1);
                end else begin
                    // Expiry sets the pending flag even if a CTRL write lands this cycle.
                    count_d    = '0;
                    irq_pend_d = 1'b1;
                    state_d    = StInt;
                end
            end
            StInt: begin
                if (auto_reload) begin
                    irq_pend_d = 1'b0;
                    state_d    = StLoad;
                end else begin
                    en_d    = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Software write overrides the hardware EN clear in the same cycle.
        if (ctrl_we) begin
            en_d   = WD[CtrlEnBit];
            mode_d = WD[CtrlModeMsb:CtrlModeLsb];
            im_d   = WD[CtrlImBit];
        end
        if (preset_we) begin
            preset_d = WD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            en_q       <= 1'b0;
            mode_q     <= ModeOneShot;
            im_q       <= 1'b0;
            preset_q   <= INIT_PRESET;
            count_q    <= '0;
            irq_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            mode_q     <= mode_d;
            im_q       <= im_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    always_comb begin
        RD = '0;
        unique case (Addr[3:2])
            OffCtrl:   RD = WIDTH'({im_q, mode_q, en_q});
            OffPreset: RD = preset_q;
            OffCount:  RD = count_q;
            default:   RD = '0;
        endcase
    end

    assign IRQ = irq_pend_q & im_q;

endmodule

// File: tb/tb_timer_counter.sv
module tb_timer_counter;

    localparam logic [31:0] InitP = 32'h0000_0007;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        IRQ;

    int total = 0;
    int bad   = 0;

    timer_counter #(
        .WIDTH      (32),
        .INIT_PRESET(InitP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .WD   (WD),
        .RD   (RD),
        .IRQ  (IRQ)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (closed-form timing rules) ----------------
    // k = number of clock edges since the edge that wrote CTRL with EN=1.
    function automatic int unsigned eff(input int unsigned n);
        return (n == 0) ? 1 : n;
    endfunction

    function automatic logic [31:0] exp_os_count(input int unsigned n, input int unsigned k);
        return (k >= n + 2) ? 32'd0 : 32'(n + 2 - k);
    endfunction

    function automatic logic exp_os_irq(input int unsigned n, input int unsigned k);
        return (k >= eff(n) + 2);
    endfunction

    function automatic logic [31:0] exp_ar_count(input int unsigned n, input int unsigned k);
        int unsigned j;
        j = (k - 2) % (eff(n) + 2);
        return (j < n) ? 32'(n - j) : 32'd0;
    endfunction

    function automatic logic exp_ar_irq(input int unsigned n, input int unsigned k);
        if (k < 2) return 1'b0;
        return ((k - 2) % (eff(n) + 2)) == eff(n);
    endfunction

    // ---------------- bus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        Addr = 32'h0000_7f00 | {28'd0, a};
        WD   = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE   = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        Addr = 32'h0000_7f00 | {28'd0, a};
        #1;
        d = RD;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step();
        rd(4'h0, d); total++;
        if (d !== 32'd0) begin bad++; $display("FAIL reset_ctrl: got %0h want 0", d); end
        rd(4'h4, d); total++;
        if (d !== InitP) begin bad++; $display("FAIL reset_preset: got %0h want %0h", d, InitP); end
        rd(4'h8, d); total++;
        if (d !== 32'd0) begin bad++; $display("FAIL reset_count: got %0h want 0", d); end
        rd(4'hC, d); total++;
        if (d !== 32'd0) begin bad++; $display("FAIL reset_rsvd: got %0h want 0", d); end
        total++;
        if (IRQ !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", IRQ); end
    endtask

    task automatic test_oneshot(input int unsigned n);
        logic [31:0] d;
        wr(4'h4, n);
        wr(4'h0, 32'h9);
        for (int unsigned k = 0; k <= eff(n) + 5; k++) begin
            if (k > 0) step();
            total++;
            if (IRQ !== exp_os_irq(n, k)) begin
                bad++; $display("FAIL oneshot_irq n=%0d k=%0d: got %b want %b", n, k, IRQ,
                                exp_os_irq(n, k));
            end
            if (k >= 2) begin
                rd(4'h8, d); total++;
                if (d !== exp_os_count(n, k)) begin
                    bad++; $display("FAIL oneshot_count n=%0d k=%0d: got %0d want %0d", n, k, d,
                                    exp_os_count(n, k));
                end
            end
        end
        rd(4'h0, d); total++;
        if (d !== 32'h8) begin bad++; $display("FAIL oneshot_en_clear: got %0h want 8", d); end
        wr(4'h0, 32'h0); total++;
        if (IRQ !== 1'b0) begin bad++; $display("FAIL oneshot_irq_off: got %b want 0", IRQ); end
    endtask

    task automatic test_autoreload(input int unsigned n);
        logic [31:0] d;
        int unsigned p;
        p = eff(n) + 2;
        wr(4'h4, n);
        wr(4'h0, 32'hB);
        for (int unsigned k = 0; k <= 2 + 3 * p; k++) begin
            if (k > 0) step();
            total++;
            if (IRQ !== exp_ar_irq(n, k)) begin
                bad++; $display("FAIL auto_irq n=%0d k=%0d: got %b want %b", n, k, IRQ,
                                exp_ar_irq(n, k));
            end
            if (k >= 2) begin
                rd(4'h8, d); total++;
                if (d !== exp_ar_count(n, k)) begin
                    bad++; $display("FAIL auto_count n=%0d k=%0d: got %0d want %0d", n, k, d,
                                    exp_ar_count(n, k));
                end
            end
        end
        wr(4'h0, 32'h0);
        repeat (4) step();
    endtask

    task automatic test_disable(input int unsigned n, input int unsigned kstop);
        logic [31:0] d;
        logic [31:0] frozen;
        wr(4'h4, n);
        wr(4'h0, 32'h9);
        for (int unsigned k = 1; k <= kstop; k++) step();
        rd(4'h8, d); total++;
        if (d !== 32'(n + 2 - kstop)) begin
            bad++; $display("FAIL dis_pre: got %0d want %0d", d, n + 2 - kstop);
        end
        // The edge that writes EN=0 still decrements once.
        wr(4'h0, 32'h8);
        frozen = 32'(n + 1 - kstop);
        for (int i = 0; i < 5; i++) begin
            step();
            rd(4'h8, d); total++;
            if (d !== frozen || IRQ !== 1'b0) begin
                bad++; $display("FAIL dis_hold i=%0d: got %0d/%b want %0d/0", i, d, IRQ, frozen);
            end
        end
        wr(4'h0, 32'h9);
        step();
        rd(4'h8, d); total++;
        if (d !== frozen) begin bad++; $display("FAIL dis_load: got %0d want %0d", d, frozen); end
        step();
        rd(4'h8, d); total++;
        if (d !== 32'(n)) begin bad++; $display("FAIL dis_reload: got %0d want %0d", d, n); end
        step();
        rd(4'h8, d); total++;
        if (d !== 32'(n - 1)) begin bad++; $display("FAIL dis_recount: got %0d want %0d", d, n - 1); end
        wr(4'h0, 32'h0);
        repeat (4) step();
    endtask

    task automatic test_mask(input int unsigned n);
        logic [31:0] d;
        logic [31:0] junk;
        wr(4'h4, n);
        wr(4'h0, 32'h1);
        repeat (eff(n) + 4) step();
        total++;
        if (IRQ !== 1'b0) begin bad++; $display("FAIL mask_irq_masked: got %b want 0", IRQ); end
        rd(4'h0, d); total++;
        if (d !== 32'h0) begin bad++; $display("FAIL mask_ctrl: got %0h want 0", d); end
        wr(4'h0, 32'h8); total++;
        if (IRQ !== 1'b1) begin bad++; $display("FAIL mask_unmask: got %b want 1", IRQ); end
        wr(4'h0, 32'h0); total++;
        if (IRQ !== 1'b0) begin bad++; $display("FAIL mask_remask: got %b want 0", IRQ); end
        wr(4'h0, 32'hFFFF_FFF8); total++;
        if (IRQ !== 1'b1) begin bad++; $display("FAIL mask_unmask2: got %b want 1", IRQ); end
        rd(4'h0, d); total++;
        if (d !== 32'h8) begin bad++; $display("FAIL ctrl_upper: got %0h want 8", d); end
        junk = $urandom | 32'h1;
        wr(4'h8, junk);
        rd(4'h8, d); total++;
        if (d !== 32'h0) begin bad++; $display("FAIL count_ro: got %0h want 0", d); end
        wr(4'hC, junk);
        rd(4'hC, d); total++;
        if (d !== 32'h0) begin bad++; $display("FAIL rsvd_ro: got %0h want 0", d); end
        rd(4'h4, d); total++;
        if (d !== 32'(n)) begin bad++; $display("FAIL preset_kept: got %0h want %0h", d, n); end
    endtask

    task automatic check_after_reset(input string tag);
        logic [31:0] d;
        total++;
        if (IRQ !== 1'b0) begin bad++; $display("FAIL %s_irq: got %b want 0", tag, IRQ); end
        rd(4'h0, d); total++;
        if (d !== 32'h0) begin bad++; $display("FAIL %s_ctrl: got %0h want 0", tag, d); end
        rd(4'h4, d); total++;
        if (d !== InitP) begin bad++; $display("FAIL %s_preset: got %0h want %0h", tag, d, InitP); end
        rd(4'h8, d); total++;
        if (d !== 32'h0) begin bad++; $display("FAIL %s_count: got %0h want 0", tag, d); end
    endtask

    task automatic test_reset_mid(input int unsigned n);
        logic [31:0] d;
        // Reset while a one-shot interrupt is pending and visible.
        wr(4'h4, 32'd2);
        wr(4'h0, 32'h9);
        repeat (6) step();
        total++;
        if (IRQ !== 1'b1) begin bad++; $display("FAIL rst_pre_irq: got %b want 1", IRQ); end
        #1 reset = 1'b1;
        #1 check_after_reset("rst_pend");
        @(negedge clk);
        reset = 1'b0;
        // Reset in the middle of an auto-reload run.
        wr(4'h4, n);
        wr(4'h0, 32'hB);
        repeat ($urandom_range(3, n + 1)) step();
        #1 reset = 1'b1;
        #1 check_after_reset("rst_cnt");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            rd(4'h8, d); total++;
            if (d !== 32'h0) begin bad++; $display("FAIL rst_idle i=%0d: got %0h want 0", i, d); end
        end
    endtask

    initial begin
        reset = 1'b1;
        Addr  = '0;
        WE    = 1'b0;
        WD    = '0;
        test_reset();
        test_oneshot(5);
        test_oneshot(0);
        test_oneshot(1);
        test_oneshot($urandom_range(2, 12));
        test_autoreload(3);
        test_autoreload(0);
        test_autoreload($urandom_range(1, 8));
        test_disable(10, 6);
        for (int i = 0; i < 3; i++) begin
            int unsigned n;
            n = $urandom_range(4, 16);
            test_disable(n, $urandom_range(2, n));
        end
        test_mask(4);
        test_mask($urandom_range(0, 9));
        test_reset_mid($urandom_range(3, 9));
        // FSM must restart from IDLE after reset.
        test_oneshot($urandom_range(1, 6));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
